// File: rtl/muldiv_unit.sv
// muldiv_unit: 32-cycle shift-add multiply / restoring divide with HI/LO, single-cycle mthi/mtlo
module muldiv_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  md_op,
  input  logic        start,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        busy,
  output logic        done
);
  localparam logic [1:0] IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2;
  logic [1:0] state;
  logic [4:0] cnt;
  logic [63:0] acc, nxt, prod;
  logic [31:0] m, a_mag, b_mag, quo, rem;
  logic [32:0] sum, diff;
  logic neg, neg_r, dz, sgn, is_mul;
  assign busy = state != IDLE;
  always_comb begin
    sgn = md_op == 3'd1 || md_op == 3'd3;
    is_mul = md_op == 3'd1 || md_op == 3'd2;
    a_mag = sgn && A[31] ? -A : A;
    b_mag = sgn && B[31] ? -B : B;
    sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, m} : 33'd0);
    diff = acc[63:31] - {1'b0, m};
    nxt = state == MUL ? {sum, acc[31:1]} : diff[32] ? {acc[62:0], 1'b0} : {diff[31:0], acc[30:0], 1'b1};
    prod = neg ? -nxt : nxt;
    quo = neg && !dz ? -nxt[31:0] : nxt[31:0];
    rem = neg_r ? -nxt[63:32] : nxt[63:32];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= 5'd0;
      acc <= 64'd0;
      m <= 32'd0;
      neg <= 1'b0;
      neg_r <= 1'b0;
      dz <= 1'b0;
      hi_out <= 32'd0;
      lo_out <= 32'd0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start && md_op >= 3'd1 && md_op <= 3'd4) begin
          state <= is_mul ? MUL : DIV;
          cnt <= 5'd0;
          m <= is_mul ? a_mag : b_mag;
          acc <= {32'd0, is_mul ? b_mag : a_mag};
          neg <= sgn && (A[31] ^ B[31]);
          neg_r <= sgn && A[31];
          dz <= B == 32'd0;
        end else if (start && md_op == 3'd5)
          hi_out <= A;
        else if (start && md_op == 3'd6)
          lo_out <= A;
      end else begin
        acc <= nxt;
        cnt <= cnt + 5'd1;
        if (cnt == 5'd31) begin
          state <= IDLE;
          done <= 1'b1;
          {hi_out, lo_out} <= state == MUL ? prod : {rem, quo};
        end
      end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed scoreboard bench for muldiv_unit
module tb_muldiv_unit;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [31:0] a = 32'd0, b = 32'd0;
  logic [2:0] op = 3'd0;
  logic [31:0] hi_out, lo_out;
  logic busy, done;
  logic [63:0] sb[$];
  logic [63:0] exp_q;
  int checks = 0, failures = 0;
  muldiv_unit dut (
    .clk(clk), .rst_n(rst_n), .A(a), .B(b), .md_op(op), .start(start),
    .hi_out(hi_out), .lo_out(lo_out), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  always @(negedge clk)
    if (done) begin
      chk("done_expected", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        exp_q = sb.pop_front();
        chk("hi_result", hi_out, exp_q[63:32]);
        chk("lo_result", lo_out, exp_q[31:0]);
      end
    end
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    op = o;
    a = x;
    b = y;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    op = 3'd0;
  endtask
  task automatic start_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el);
    sb.push_back({eh, el});
    issue(o, x, y);
  endtask
  task automatic finish_op(input int cycles);
    int n = 0;
    repeat (40) begin
      if (!busy) break;
      n++;
      @(negedge clk);
    end
    chk("busy_cycles", n, cycles);
    @(negedge clk);
    chk("done_pulse_drop", {31'd0, done}, 32'd0);
    chk("idle_after", {31'd0, busy}, 32'd0);
    chk("sb_drained", sb.size(), 32'd0);
  endtask
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el);
    start_op(o, x, y, eh, el);
    finish_op(32);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_hi", hi_out, 32'd0);
    chk("rst_lo", lo_out, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;
    run_op(3'd1, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB);
    run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_op(3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
    run_op(3'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op(3'd4, 32'd7, 32'd2, 32'd1, 32'd3);
    run_op(3'd3, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD);
    run_op(3'd3, 32'h1234, 32'd0, 32'h1234, 32'hFFFFFFFF);
    run_op(3'd3, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF);
    run_op(3'd4, 32'h80000000, 32'd0, 32'h80000000, 32'hFFFFFFFF);
    run_op(3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    issue(3'd6, 32'hCAFE, 32'd0);
    chk("mtlo_lo", lo_out, 32'hCAFE);
    chk("mtlo_hi_kept", hi_out, 32'h00000000);
    chk("mtlo_busy", {31'd0, busy}, 32'd0);
    chk("mtlo_done", {31'd0, done}, 32'd0);
    issue(3'd7, 32'h55, 32'h66);
    chk("nop_busy", {31'd0, busy}, 32'd0);
    chk("nop_lo", lo_out, 32'hCAFE);
    start_op(3'd1, 32'd6, 32'd7, 32'd0, 32'd42);
    start = 1'b1;
    op = 3'd5;
    a = 32'd5;
    @(negedge clk);
    op = 3'd3;
    a = 32'd100;
    b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    op = 3'd0;
    chk("inflight_hi_stale", hi_out, 32'h00000000);
    chk("inflight_lo_stale", lo_out, 32'hCAFE);
    finish_op(30);
    issue(3'd5, 32'hDEAD, 32'd0);
    chk("mthi_hi", hi_out, 32'hDEAD);
    chk("mthi_done", {31'd0, done}, 32'd0);
    issue(3'd1, 32'd3, 32'd4);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_hi", hi_out, 32'd0);
    chk("abort_lo", lo_out, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("abort_no_result", lo_out, 32'd0);
    run_op(3'd1, 32'd3, 32'd4, 32'd0, 32'd12);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
